gauss5_window: RTL and testbench

Downstream stage of the 5-row line buffer. Each accepted beat carries one padded column of five vertically aligned pixels (`in_d0`..`in_d4`). The block keeps a 5x5 sliding window and applies a separable 1-4-6-4-1 binomial (Gaussian) kernel with rounding. It emits one filtered pixel per window position on an AXI-Stream-style master with row and frame markers.

---
 rtl/gauss5_pkg.sv | 42 ++++
 rtl/wsum5.sv | 39 +++
 rtl/gauss5_window.sv | 204 ++++++++++++++++++++
 tb/tb_gauss5_window.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gauss5_pkg.sv
// Shared constants, types and width helpers for the 5x5 binomial filter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: kernel taps and their sum, normalising shift and rounding
// constant, TUSER bit positions, marker bundle type, width functions.
package gauss5_pkg;

  // 1-4-6-4-1 binomial taps, applied vertically then horizontally.
  localparam int K_T0 = 1;
  localparam int K_T1 = 4;
  localparam int K_T2 = 6;
  localparam int K_T3 = 4;
  localparam int K_T4 = 1;

  // One 1-D pass multiplies the pixel range by the tap sum (16), so each
  // pass adds log2(16) = 4 bits and the 2-D kernel normalises by >> 8.
  localparam int KSUM   = K_T0 + K_T1 + K_T2 + K_T3 + K_T4;
  localparam int KBITS  = $clog2(KSUM);
  localparam int KSHIFT = 2 * KBITS;
  localparam int KROUND = 1 << (KSHIFT - 1);

  // TUSER bit positions, shared by the slave and master sides.
  localparam int TU_SOL = 0;
  localparam int TU_SOF = 1;

  // Row/frame markers carried alongside each pixel through the pipeline.
  typedef struct packed {
    logic sof;
    logic sol;
    logic eol;
  } mark_t;

  function automatic int vsum_w(input int pd);
    return pd + KBITS;
  endfunction

  function automatic int hsum_w(input int pd);
    return pd + 2 * KBITS;
  endfunction

endpackage

// File: rtl/wsum5.sv
// Five-input 1-4-6-4-1 weighted sum built only from shifts and adds.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
//
// Ports: i_a0..i_a4 operands in tap order, o_sum weighted sum (IW+4 bits,
// wide enough for 16 * (2^IW - 1), so it cannot overflow).
module wsum5 #(
  parameter int IW = 4,
  parameter int OW = IW + 4
) (
  input  logic [IW-1:0] i_a0,
  input  logic [IW-1:0] i_a1,
  input  logic [IW-1:0] i_a2,
  input  logic [IW-1:0] i_a3,
  input  logic [IW-1:0] i_a4,
  output logic [OW-1:0] o_sum
);

  logic [OW-1:0] w_e0;
  logic [OW-1:0] w_e1;
  logic [OW-1:0] w_e2;
  logic [OW-1:0] w_e3;
  logic [OW-1:0] w_e4;

  // Zero-extend first so every shifted partial product keeps its top bits.
  assign w_e0 = OW'(i_a0);
  assign w_e1 = OW'(i_a1);
  assign w_e2 = OW'(i_a2);
  assign w_e3 = OW'(i_a3);
  assign w_e4 = OW'(i_a4);

  // 6*x is formed as 4*x + 2*x.
  assign o_sum = w_e0
               + (w_e1 << 2)
               + (w_e2 << 2) + (w_e2 << 1)
               + (w_e3 << 2)
               + w_e4;

endmodule

// File: rtl/gauss5_window.sv
// 5x5 binomial (Gaussian) filter over padded columns from a 5-row line buffer.
// Latency: 3 cycles from the beat completing a window to its output pixel.
// Backpressure: single global enable; a held output stalls every stage and drops s_tready.
//
// Ports:
//   clock, resetn        - clock, asynchronous active-low reset
//   s_tvalid/s_tready    - input column handshake
//   s_tuser[1:0]         - [0] first column of padded row, [1] first row of frame
//   in_d0..in_d4         - column taps, top to bottom
//   o_pix                - filtered pixel
//   m_tvalid/m_tready    - output handshake
//   m_tuser[1:0]         - [0] first pixel of row, [1] first pixel of frame
//   m_tlast              - last pixel of row
module gauss5_window
  import gauss5_pkg::*;
#(
  parameter int pix_depth   = 4,
  parameter int frame_width = 10
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  input  logic [1:0]           s_tuser,
  input  logic [pix_depth-1:0] in_d0,
  input  logic [pix_depth-1:0] in_d1,
  input  logic [pix_depth-1:0] in_d2,
  input  logic [pix_depth-1:0] in_d3,
  input  logic [pix_depth-1:0] in_d4,
  output logic [pix_depth-1:0] o_pix,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic [1:0]           m_tuser,
  output logic                 m_tlast
);

  localparam int VW   = vsum_w(pix_depth);
  localparam int HW   = hsum_w(pix_depth);
  localparam int NCOL = frame_width + 4;
  localparam int CW   = $clog2(NCOL);

  // ---------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------
  logic r_run;
  logic r_mvld;
  logic w_adv;
  logic w_acc;

  // The whole pipeline freezes only while an output is offered and refused.
  assign w_adv    = !(r_mvld && !m_tready);
  assign s_tready = r_run && w_adv;
  assign w_acc    = s_tvalid && s_tready;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Column tracking
  // ---------------------------------------------------------------------
  logic [CW-1:0] r_col;      // column index the next accepted beat will take
  logic [CW-1:0] w_cidx;     // column index of the beat on the bus now
  logic          r_sync;     // a row marker has been seen since reset
  logic          r_sof_row;  // current row started with a frame marker
  logic          w_sof_cur;

  // A row marker forces column 0 wherever the counter was, which is what
  // discards a partial row: the window must refill from five new columns
  // before the index reaches 4 again.
  assign w_cidx    = s_tuser[TU_SOL] ? '0 : r_col;
  assign w_sof_cur = (w_cidx == '0) ? (s_tuser[TU_SOL] && s_tuser[TU_SOF])
                                    : r_sof_row;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_col     <= '0;
      r_sync    <= 1'b0;
      r_sof_row <= 1'b0;
    end else if (w_acc) begin
      r_col <= (w_cidx == CW'(NCOL - 1)) ? '0 : w_cidx + CW'(1);
      if (s_tuser[TU_SOL]) begin
        r_sync <= 1'b1;
      end
      if (w_cidx == '0) begin
        r_sof_row <= s_tuser[TU_SOL] && s_tuser[TU_SOF];
      end
    end
  end

  // ---------------------------------------------------------------------
  // S1: vertical sum and column tag
  // ---------------------------------------------------------------------
  logic [VW-1:0] w_vsum;
  logic [VW-1:0] r1_v;
  logic          r1_vld;     // a column was accepted: shift the window
  logic          r1_ok;      // column belongs to a row that began with a marker
  logic [CW-1:0] r1_cidx;
  logic          r1_sof;

  wsum5 #(.IW(pix_depth), .OW(VW)) u_vsum (
    .i_a0  (in_d0),
    .i_a1  (in_d1),
    .i_a2  (in_d2),
    .i_a3  (in_d3),
    .i_a4  (in_d4),
    .o_sum (w_vsum)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r1_v    <= '0;
      r1_vld  <= 1'b0;
      r1_ok   <= 1'b0;
      r1_cidx <= '0;
      r1_sof  <= 1'b0;
    end else if (w_adv) begin
      r1_vld <= w_acc;
      if (w_acc) begin
        r1_v    <= w_vsum;
        r1_ok   <= r_sync || s_tuser[TU_SOL];
        r1_cidx <= w_cidx;
        r1_sof  <= w_sof_cur;
      end
    end
  end

  // ---------------------------------------------------------------------
  // S2: window shift and horizontal sum
  // ---------------------------------------------------------------------
  // Only the four newest columns are kept: the oldest one drops out in the
  // same shift that brings r1_v in, so the sum is taken over {r_win, r1_v}
  // and registered together with the shift.
  logic [VW-1:0] r_win [0:3];
  logic [HW-1:0] w_hsum;
  logic [HW-1:0] r2_h;
  logic          r2_vld;
  mark_t         r2_mk;

  wsum5 #(.IW(VW), .OW(HW)) u_hsum (
    .i_a0  (r_win[0]),
    .i_a1  (r_win[1]),
    .i_a2  (r_win[2]),
    .i_a3  (r_win[3]),
    .i_a4  (r1_v),
    .o_sum (w_hsum)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 4; i++) begin
        r_win[i] <= '0;
      end
      r2_h   <= '0;
      r2_vld <= 1'b0;
      r2_mk  <= '0;
    end else if (w_adv) begin
      r2_vld <= r1_vld && r1_ok && (r1_cidx >= CW'(4));
      if (r1_vld) begin
        r_win[0]  <= r_win[1];
        r_win[1]  <= r_win[2];
        r_win[2]  <= r_win[3];
        r_win[3]  <= r1_v;
        r2_h      <= w_hsum;
        r2_mk.sol <= (r1_cidx == CW'(4));
        r2_mk.sof <= (r1_cidx == CW'(4)) && r1_sof;
        r2_mk.eol <= (r1_cidx == CW'(NCOL - 1));
      end
    end
  end

  // ---------------------------------------------------------------------
  // S3: round, normalise and present
  // ---------------------------------------------------------------------
  // (h + 128) >> 8 is bounded by 2^pix_depth - 1 because the kernel sums to
  // 256, so truncating to pix_depth bits never loses information.
  logic [pix_depth-1:0] r_pix;
  mark_t                r_mk;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_mvld <= 1'b0;
      r_pix  <= '0;
      r_mk   <= '0;
    end else if (w_adv) begin
      r_mvld <= r2_vld;
      r_mk   <= r2_vld ? r2_mk : '0;
      if (r2_vld) begin
        r_pix <= pix_depth'((r2_h + HW'(KROUND)) >> KSHIFT);
      end
    end
  end

  assign o_pix           = r_pix;
  assign m_tvalid        = r_mvld;
  assign m_tuser[TU_SOL] = r_mk.sol;
  assign m_tuser[TU_SOF] = r_mk.sof;
  assign m_tlast         = r_mk.eol;

endmodule

// File: tb/tb_gauss5_window.sv
module tb_gauss5_window;

  logic       clock;
  logic       resetn;
  logic       s_tvalid;
  logic       s_tready;
  logic [1:0] s_tuser;
  logic [3:0] in_d0, in_d1, in_d2, in_d3, in_d4;
  logic [3:0] o_pix;
  logic       m_tvalid;
  logic       m_tready;
  logic [1:0] m_tuser;
  logic       m_tlast;

  gauss5_window #(.pix_depth(4), .frame_width(10)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tuser  (s_tuser),
    .in_d0    (in_d0),
    .in_d1    (in_d1),
    .in_d2    (in_d2),
    .in_d3    (in_d3),
    .in_d4    (in_d4),
    .o_pix    (o_pix),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tuser  (m_tuser),
    .m_tlast  (m_tlast)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int q_pix[$];
  int q_user[$];
  int q_last[$];
  int q_cyc[$];
  int exp_pix[$];

  int   stall_cnt = 0;
  int   hold_err  = 0;
  int   rdy_err   = 0;
  bit   prev_stall = 0;
  logic [3:0] p_pix;
  logic [1:0] p_user;
  logic       p_last;

  bit       bp_en = 0;
  bit [3:0] bp_pat = 4'b1001;  // read LSB first: ready 1,0,0,1

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Cycle counter: value after the most recent rising edge.
  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Downstream ready: always 1 unless the backpressure pattern is enabled.
  initial begin
    int k;
    k = 0;
    forever begin
      @(posedge clock);
      #1;
      if (bp_en) begin
        m_tready = bp_pat[k];
        k = (k + 1) % 4;
      end else begin
        m_tready = 1'b1;
        k = 0;
      end
    end
  end

  // Output monitor, sampled on the falling edge.
  initial forever begin
    @(negedge clock);
    if (!resetn) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        if (!m_tvalid || o_pix !== p_pix || m_tuser !== p_user || m_tlast !== p_last)
          hold_err++;
      end
      if (m_tvalid && m_tready) begin
        q_pix.push_back(int'(o_pix));
        q_user.push_back(int'(m_tuser));
        q_last.push_back(int'(m_tlast));
        q_cyc.push_back(cyc);
      end
      if (m_tvalid && !m_tready) begin
        stall_cnt++;
        if (s_tready) rdy_err++;
        prev_stall = 1;
        p_pix  = o_pix;
        p_user = m_tuser;
        p_last = m_tlast;
      end else begin
        prev_stall = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send_col(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2,
                          input logic [3:0] d3, input logic [3:0] d4, input logic [1:0] u,
                          output int acc_cyc);
    int t;
    bit ok;
    s_tvalid = 1'b1;
    s_tuser  = u;
    in_d0 = d0; in_d1 = d1; in_d2 = d2; in_d3 = d3; in_d4 = d4;
    ok = 0;
    for (t = 0; t < 100; t++) begin
      @(negedge clock);
      if (s_tready) begin
        ok = 1;
        break;
      end
      @(posedge clock);
      #1;
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge clock);
    #1;
    acc_cyc  = cyc;
    s_tvalid = 1'b0;
    s_tuser  = 2'b00;
  endtask

  task automatic send_flat(input logic [3:0] v, input logic [1:0] u, input int ncols,
                           output int acc4);
    int a;
    acc4 = 0;
    for (int c = 0; c < ncols; c++) begin
      send_col(v, v, v, v, v, (c == 0) ? u : 2'b00, a);
      if (c == 4) acc4 = a;
    end
  endtask

  task automatic wait_outs(input int n);
    int t;
    t = 0;
    while (q_pix.size() < n && t < 400) begin
      @(posedge clock);
      t++;
    end
    repeat (10) @(posedge clock);
    #1;
  endtask

  task automatic clear_q();
    q_pix.delete();
    q_user.delete();
    q_last.delete();
    q_cyc.delete();
    exp_pix.delete();
  endtask

  task automatic check_outs(input string tag, input int n, input int first_user);
    chk({tag, "_count"}, q_pix.size(), n);
    for (int i = 0; i < n && i < q_pix.size(); i++) begin
      chk($sformatf("%s_pix%0d", tag, i), q_pix[i], exp_pix[i]);
      chk($sformatf("%s_user%0d", tag, i), q_user[i], (i == 0) ? first_user : 0);
      chk($sformatf("%s_last%0d", tag, i), q_last[i], (i == n - 1) ? 1 : 0);
    end
  endtask

  initial begin
    int a4;
    int dummy;

    resetn   = 1'b0;
    s_tvalid = 1'b0;
    s_tuser  = 2'b00;
    in_d0 = '0; in_d1 = '0; in_d2 = '0; in_d3 = '0; in_d4 = '0;
    m_tready = 1'b1;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_s_tready", s_tready, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_o_pix",    o_pix,    0);
    chk("rst_m_tuser",  m_tuser,  0);
    chk("rst_m_tlast",  m_tlast,  0);
    resetn = 1'b1;
    @(posedge clock);
    #1;

    // Flat field 7, start of frame: 16*7=112 per column, 256*7=1792, +128 >>8 = 7
    clear_q();
    repeat (10) exp_pix.push_back(7);
    send_flat(4'd7, 2'b11, 14, a4);
    wait_outs(10);
    check_outs("flat", 10, 3);
    if (q_cyc.size() >= 10) begin
      chk("flat_latency", q_cyc[0] - a4, 2);
      chk("flat_burst",   q_cyc[9] - q_cyc[0], 9);
    end else begin
      chk("flat_cyc_count", q_cyc.size(), 10);
    end

    // Max value: 256*15 + 128 = 3968, >>8 = 15
    clear_q();
    repeat (10) exp_pix.push_back(15);
    send_flat(4'd15, 2'b01, 14, dummy);
    wait_outs(10);
    check_outs("max", 10, 1);

    // Impulse: column 4 vertical sum 6*15 = 90; horizontal weight by position
    // j=0:90->0, j=1:360->1, j=2:540->2, j=3:360->1, j=4:90->0
    clear_q();
    exp_pix.push_back(0); exp_pix.push_back(1); exp_pix.push_back(2);
    exp_pix.push_back(1); exp_pix.push_back(0);
    repeat (5) exp_pix.push_back(0);
    for (int c = 0; c < 14; c++) begin
      if (c == 4) send_col(4'd0, 4'd0, 4'd15, 4'd0, 4'd0, 2'b00, dummy);
      else        send_col(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, (c == 0) ? 2'b01 : 2'b00, dummy);
    end
    wait_outs(10);
    check_outs("impulse", 10, 1);

    // Backpressure: flat 9 with ready pattern 1-0-0-1
    clear_q();
    stall_cnt = 0;
    hold_err  = 0;
    rdy_err   = 0;
    repeat (10) exp_pix.push_back(9);
    bp_en = 1;
    send_flat(4'd9, 2'b01, 14, dummy);
    wait_outs(10);
    bp_en = 0;
    @(posedge clock);
    #1;
    check_outs("bp", 10, 1);
    chk("bp_stalls_seen", (stall_cnt > 0) ? 1 : 0, 1);
    chk("bp_hold_err",    hold_err, 0);
    chk("bp_rdy_err",     rdy_err,  0);

    // Resync: partial row of 15s (cols 0..5), then a new marker row of 2s
    clear_q();
    for (int c = 0; c < 6; c++) begin
      send_col(4'd15, 4'd15, 4'd15, 4'd15, 4'd15, (c == 0) ? 2'b01 : 2'b00, dummy);
    end
    repeat (12) @(posedge clock);
    #1;
    clear_q();
    repeat (10) exp_pix.push_back(2);
    send_flat(4'd2, 2'b01, 14, dummy);
    wait_outs(10);
    check_outs("resync", 10, 1);

    // Reset mid-operation: 8 columns of 5 so outputs are flowing
    clear_q();
    send_flat(4'd5, 2'b11, 8, dummy);
    chk("prerst_m_tvalid", m_tvalid, 1);
    chk("prerst_o_pix",    o_pix,    5);
    resetn = 1'b0;
    #1;
    chk("midrst_m_tvalid", m_tvalid, 0);
    chk("midrst_o_pix",    o_pix,    0);
    chk("midrst_m_tuser",  m_tuser,  0);
    chk("midrst_m_tlast",  m_tlast,  0);
    chk("midrst_s_tready", s_tready, 0);
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
    @(negedge clock);
    chk("rel_s_tready_before_edge", s_tready, 0);
    @(posedge clock);
    #1;
    chk("rel_s_tready_after_edge", s_tready, 1);

    clear_q();
    repeat (10) exp_pix.push_back(6);
    send_flat(4'd6, 2'b11, 14, dummy);
    wait_outs(10);
    check_outs("post_rst", 10, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
